// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - runtime-programmable clock divider with clean start/stop
// Divisor changes requested while running are parked and applied only at a period wrap.
module clock_divider_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [DIV_W-1:0] ZERO    = '0;
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RST);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic accept, legal, wrap, run_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;

    accept = cfg_valid & ~pend_v_q;
    legal  = (cfg_div >= TWO);
    wrap   = (state_q != S_IDLE) && (cnt_q == cur_div_q - ONE);

    case (state_q)
      S_IDLE: begin
        // A divisor parked on the last cycle of a stop is flushed here.
        if (pend_v_q) begin
          cur_div_d = pend_q;
          pend_v_d  = 1'b0;
        end
        if (accept && legal) cur_div_d = cfg_div;
        if (en) begin
          state_d = S_RUN;
          cnt_d   = ZERO;
        end
      end
      S_RUN, S_STOP: begin
        cnt_d = wrap ? ZERO : cnt_q + ONE;
        if (wrap && pend_v_q) begin
          cur_div_d = pend_q;
          pend_v_d  = 1'b0;
        end
        if (accept && legal) begin
          pend_d   = cfg_div;
          pend_v_d = 1'b1;
        end
        if (state_q == S_RUN) begin
          if (!en) state_d = S_STOP;
        end else if (en) begin
          state_d = S_RUN;
        end else if (wrap) begin
          state_d = S_IDLE;
          cnt_d   = ZERO;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = ZERO;
      end
    endcase

    // Outputs are registered from next-state values so they line up with cnt_q.
    run_d     = (state_d != S_IDLE);
    clk_div_d = run_d && (cnt_d < (cur_div_d >> 1));
    tick_d    = run_d && (cnt_d == cur_div_d - ONE);
    cfg_err_d = accept && !legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= ZERO;
      cur_div_q <= RST_DIV;
      pend_q    <= ZERO;
      pend_v_q  <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ready = ~pend_v_q;
  assign cfg_err   = cfg_err_q;
  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign cur_div   = cur_div_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - directed and randomized checks of clock_divider_ctrl
module tb_clock_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, clk_div, tick, busy;
  logic [7:0] cur_div;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_ctrl #(.DIV_W(8), .DIV_RST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_div(clk_div), .tick(tick),
    .cur_div(cur_div), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: active/draining flags, position inside the period, divisor, pending queue
  bit m_active, m_draining, m_err;
  int m_pos, m_cur;
  int pendq[$];

  task automatic model_reset();
    m_active = 0; m_draining = 0; m_err = 0; m_pos = 0; m_cur = 4;
    pendq.delete();
  endtask

  task automatic model_step();
    bit acc, bad, boundary;
    acc = cfg_valid && (pendq.size() == 0);
    bad = acc && (cfg_div < 2);
    if (!m_active) begin
      if (pendq.size() > 0) m_cur = pendq.pop_front();
      if (acc && !bad) m_cur = int'(cfg_div);
      if (en) begin m_active = 1; m_draining = 0; m_pos = 0; end
    end else begin
      boundary = (m_pos == m_cur - 1);
      m_pos = boundary ? 0 : m_pos + 1;
      if (boundary && pendq.size() > 0) m_cur = pendq.pop_front();
      if (acc && !bad) pendq.push_back(int'(cfg_div));
      if (m_draining && !en && boundary) begin m_active = 0; m_pos = 0; end
      m_draining = !en;
    end
    m_err = bad;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    model_reset();
    #3;
    n_checks++; if (clk_div !== 1'b0) begin n_fail++; $display("FAIL reset_clk_div got %b want 0", clk_div); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (cur_div !== 8'd4) begin n_fail++; $display("FAIL reset_cur_div got %0d want 4", cur_div); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_n4();
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_checks++; if (clk_div !== (((k - 1) % 4) < 2)) begin n_fail++; $display("FAIL n4_clk_div k=%0d got %b", k, clk_div); end
      n_checks++; if (tick !== ((k % 4) == 0)) begin n_fail++; $display("FAIL n4_tick k=%0d got %b", k, tick); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL n4_busy k=%0d got %b want 1", k, busy); end
    end
  endtask

  task automatic test_retarget();
    int guard = 0;
    while (tick !== 1'b1 && guard < 10) begin cycle(); guard++; end
    n_checks++; if (guard >= 10) begin n_fail++; $display("FAIL retarget_wait_tick timeout got %0d cycles want <10", guard); end
    cycle(); cycle();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    cycle();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL retarget_ready_low got %b want 0", cfg_ready); end
    n_checks++; if (cur_div !== 8'd4) begin n_fail++; $display("FAIL retarget_cur_old got %0d want 4", cur_div); end
    cycle();
    n_checks++; if (tick !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL retarget_last tick=%b ready=%b want 1,0", tick, cfg_ready); end
    cycle();
    n_checks++; if (cur_div !== 8'd6) begin n_fail++; $display("FAIL retarget_cur_new got %0d want 6", cur_div); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL retarget_ready_back got %b want 1", cfg_ready); end
    for (int p = 0; p < 6; p++) begin
      n_checks++; if (clk_div !== (p < 3)) begin n_fail++; $display("FAIL retarget_clk p=%0d got %b", p, clk_div); end
      n_checks++; if (tick !== (p == 5)) begin n_fail++; $display("FAIL retarget_tick p=%0d got %b", p, tick); end
      cycle();
    end
  endtask

  task automatic test_odd();
    int guard = 0;
    cfg_valid = 1'b1; cfg_div = 8'd5;
    cycle();
    cfg_valid = 1'b0;
    while (cur_div !== 8'd5 && guard < 20) begin cycle(); guard++; end
    n_checks++; if (guard >= 20) begin n_fail++; $display("FAIL odd_wait timeout cur_div=%0d want 5", cur_div); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (clk_div !== ((i % 5) < 2)) begin n_fail++; $display("FAIL odd_clk i=%0d got %b", i, clk_div); end
      n_checks++; if (tick !== ((i % 5) == 4)) begin n_fail++; $display("FAIL odd_tick i=%0d got %b", i, tick); end
      cycle();
    end
  endtask

  task automatic test_stop();
    int guard = 0;
    cfg_valid = 1'b1; cfg_div = 8'd4;
    cycle();
    cfg_valid = 1'b0;
    while (cur_div !== 8'd4 && guard < 20) begin cycle(); guard++; end
    n_checks++; if (guard >= 20) begin n_fail++; $display("FAIL stop_wait timeout cur_div=%0d want 4", cur_div); end
    cycle();
    en = 1'b0;
    cycle();
    n_checks++; if (busy !== 1'b1 || clk_div !== 1'b0) begin n_fail++; $display("FAIL stop_pos2 busy=%b clk=%b want 1,0", busy, clk_div); end
    cycle();
    n_checks++; if (tick !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_pos3 tick=%b busy=%b want 1,1", tick, busy); end
    cycle();
    n_checks++; if (busy !== 1'b0 || clk_div !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL stop_idle busy=%b clk=%b tick=%b want 0,0,0", busy, clk_div, tick); end
    cycle();
    n_checks++; if (busy !== 1'b0 || clk_div !== 1'b0) begin n_fail++; $display("FAIL stop_idle2 busy=%b clk=%b want 0,0", busy, clk_div); end
    en = 1'b1;
    cycle();
    n_checks++; if (clk_div !== 1'b1 || busy !== 1'b1 || tick !== 1'b0) begin n_fail++; $display("FAIL restart clk=%b busy=%b tick=%b want 1,1,0", clk_div, busy, tick); end
    en = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 10) begin cycle(); guard++; end
    n_checks++; if (guard >= 10) begin n_fail++; $display("FAIL stop_drain timeout busy=%b want 0", busy); end
  endtask

  task automatic test_cfg_err();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cycle();
    n_checks++; if (cfg_err !== 1'b1 || cur_div !== 8'd4) begin n_fail++; $display("FAIL err_div1 err=%b cur=%0d want 1,4", cfg_err, cur_div); end
    cfg_valid = 1'b0;
    cycle();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len got %b want 0", cfg_err); end
    cfg_valid = 1'b1; cfg_div = 8'd0;
    cycle();
    n_checks++; if (cfg_err !== 1'b1 || cur_div !== 8'd4) begin n_fail++; $display("FAIL err_div0 err=%b cur=%0d want 1,4", cfg_err, cur_div); end
    cfg_div = 8'd7;
    cycle();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b0 || cur_div !== 8'd7 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_apply err=%b cur=%0d ready=%b want 0,7,1", cfg_err, cur_div, cfg_ready); end
    cycle();
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    cycle();
    cfg_valid = 1'b0; en = 1'b1;
    cycle(); cycle();
    cfg_valid = 1'b1; cfg_div = 8'd9;
    cycle();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || clk_div !== 1'b1 || cur_div !== 8'd6) begin n_fail++; $display("FAIL rstmid_pre ready=%b clk=%b cur=%0d want 0,1,6", cfg_ready, clk_div, cur_div); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (clk_div !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_out clk=%b busy=%b tick=%b want 0,0,0", clk_div, busy, tick); end
    n_checks++; if (cur_div !== 8'd4 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cfg cur=%0d ready=%b want 4,1", cur_div, cfg_ready); end
    en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(); cycle();
    n_checks++; if (cur_div !== 8'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost cur=%0d busy=%b want 4,0", cur_div, busy); end
  endtask

  task automatic test_random();
    bit exp_clk, exp_tick, exp_ready, exp_busy;
    int exp_cur;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) cfg_div = 8'($urandom_range(0, 1));
      else if ($urandom_range(0, 49) == 0) cfg_div = 8'($urandom_range(2, 40));
      else cfg_div = 8'($urandom_range(2, 9));
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      cycle();
      exp_clk   = m_active && (m_pos < m_cur / 2);
      exp_tick  = m_active && (m_pos == m_cur - 1);
      exp_ready = (pendq.size() == 0);
      exp_busy  = m_active;
      exp_cur   = m_cur;
      n_checks++; if (clk_div !== exp_clk) begin n_fail++; $display("FAIL rnd_clk_div i=%0d got %b want %b", i, clk_div, exp_clk); end
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL rnd_tick i=%0d got %b want %b", i, tick, exp_tick); end
      n_checks++; if (cfg_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready i=%0d got %b want %b", i, cfg_ready, exp_ready); end
      n_checks++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rnd_err i=%0d got %b want %b", i, cfg_err, m_err); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, exp_busy); end
      n_checks++; if (int'(cur_div) !== exp_cur) begin n_fail++; $display("FAIL rnd_cur_div i=%0d got %0d want %0d", i, cur_div, exp_cur); end
      rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_n4();
    test_retarget();
    test_odd();
    test_stop();
    test_cfg_err();
    test_reset_mid();
    en = 1'b0;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
